// File: rtl/prim_skid_slice.sv
// Ready/valid register slice with main + skid storage; registers both valid/data and ready paths.
// Optional payload parity protection enabled by defining PRIM_SKID_SLICE_PARITY_EN.
module prim_skid_slice #(
   parameter int               Width      = 32,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_data_o,
   output logic             err_o
);

`ifdef PRIM_SKID_SLICE_PARITY_EN
   // Stored word carries an even-parity bit above the payload.
   localparam int                  StoreWidth = Width + 1;
   localparam logic [StoreWidth-1:0] ResetWord = {^ResetValue, ResetValue};
   logic [StoreWidth-1:0] in_word;
   assign in_word = {^in_data_i, in_data_i};
`else
   localparam int                  StoreWidth = Width;
   localparam logic [StoreWidth-1:0] ResetWord = ResetValue;
   logic [StoreWidth-1:0] in_word;
   assign in_word = in_data_i;
`endif

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                state_reg, state_next;
   logic                  ready_reg, valid_reg;
   logic [StoreWidth-1:0] main_reg, skid_reg, main_next;
   logic                  main_en, skid_en;
   logic                  in_fire, out_fire;

   assign in_ready_o  = ready_reg & ~flush_i;
   assign out_valid_o = valid_reg;
   assign out_data_o  = main_reg[Width-1:0];
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = valid_reg & out_ready_i;

   always_comb begin
      state_next = state_reg;
      main_en    = 1'b0;
      skid_en    = 1'b0;
      main_next  = in_word;
      case (state_reg)
         EMPTY: begin
            if (in_fire) begin
               state_next = ONE;
               main_en    = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               main_en = 1'b1;
            end else if (in_fire) begin
               state_next = FULL;
               skid_en    = 1'b1;
            end else if (out_fire) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_next = ONE;
               main_en    = 1'b1;
               main_next  = skid_reg;
            end
         end
         default: state_next = EMPTY;
      endcase
      // Flush drops everything buffered; storage is left untouched.
      if (flush_i) begin
         state_next = EMPTY;
         main_en    = 1'b0;
         skid_en    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= EMPTY;
         ready_reg <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         ready_reg <= (state_next != FULL);
         valid_reg <= (state_next != EMPTY);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_reg <= ResetWord;
         skid_reg <= ResetWord;
      end else begin
         if (main_en) main_reg <= main_next;
         if (skid_en) skid_reg <= in_word;
      end
   end

`ifdef PRIM_SKID_SLICE_PARITY_EN
   assign err_o = valid_reg & (^main_reg);
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_skid_slice.sv
// Self-checking bench for prim_skid_slice: directed vector table, streaming,
// random scoreboard run, asynchronous mid-transfer reset and optional parity check.
module tb_prim_skid_slice;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] in_data_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] out_data_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   prim_skid_slice #(.Width(32), .ResetValue('0)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        flush;
      logic        iv;
      logic [31:0] din;
      logic        ordy;
      logic        ex_rdy;
      logic        ex_vld;
      logic [31:0] ex_data;
   } vec_t;

   localparam int NumVec = 19;
   vec_t vecs [NumVec];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 50) $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
      @(negedge clk_i);
      flush_i     = f;
      in_valid_i  = iv;
      in_data_i   = d;
      out_ready_i = ordy;
      #1;
   endtask

   logic [31:0] sb [$];
   logic        m_rdy, m_vld, r_iv, r_or, r_fl;

   initial begin
      // flush, in_valid, in_data, out_ready -> in_ready, out_valid, out_data
      vecs[0]  = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA5A5A5A5};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 1'b1, 32'h1,        1'b0, 1'b1, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 1'b1, 32'h2,        1'b0, 1'b1, 1'b1, 32'h1};
      vecs[5]  = '{1'b0, 1'b1, 32'h3,        1'b0, 1'b0, 1'b1, 32'h1};
      vecs[6]  = '{1'b0, 1'b1, 32'h3,        1'b1, 1'b0, 1'b1, 32'h1};
      vecs[7]  = '{1'b0, 1'b1, 32'h3,        1'b1, 1'b1, 1'b1, 32'h2};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h3};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
      vecs[10] = '{1'b0, 1'b1, 32'h7,        1'b0, 1'b1, 1'b0, 32'h0};
      vecs[11] = '{1'b0, 1'b1, 32'h8,        1'b0, 1'b1, 1'b1, 32'h7};
      vecs[12] = '{1'b1, 1'b1, 32'h9,        1'b0, 1'b0, 1'b1, 32'h7};
      vecs[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
      vecs[14] = '{1'b1, 1'b1, 32'hB,        1'b1, 1'b0, 1'b0, 32'h0};
      vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
      vecs[16] = '{1'b0, 1'b1, 32'hC,        1'b1, 1'b1, 1'b0, 32'h0};
      vecs[17] = '{1'b1, 1'b1, 32'hD,        1'b1, 1'b0, 1'b1, 32'hC};
      vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};

      // Reset state
      @(negedge clk_i);
      #1;
      chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_out_data", out_data_o, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("rel_in_ready_before_edge", {31'd0, in_ready_o}, 32'd0);

      for (int i = 0; i < NumVec; i++) begin
         drive(vecs[i].flush, vecs[i].iv, vecs[i].din, vecs[i].ordy);
         $display("vec %0d flush=%0b iv=%0b din=%h ordy=%0b -> rdy=%0b vld=%0b dout=%h",
                  i, flush_i, in_valid_i, in_data_i, out_ready_i, in_ready_o, out_valid_o, out_data_o);
         chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready_o}, {31'd0, vecs[i].ex_rdy});
         chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid_o}, {31'd0, vecs[i].ex_vld});
         if (vecs[i].ex_vld) chk($sformatf("vec%0d_out_data", i), out_data_o, vecs[i].ex_data);
         chk($sformatf("vec%0d_err", i), {31'd0, err_o}, 32'd0);
      end

      // Back-to-back streaming of 0..15
      for (int k = 0; k < 18; k++) begin
         drive(1'b0, k < 16, k, 1'b1);
         $display("stream %0d rdy=%0b vld=%0b dout=%h", k, in_ready_o, out_valid_o, out_data_o);
         chk($sformatf("stream%0d_in_ready", k), {31'd0, in_ready_o}, 32'd1);
         chk($sformatf("stream%0d_out_valid", k), {31'd0, out_valid_o}, {31'd0, (k >= 1 && k <= 16)});
         if (k >= 1 && k <= 16) chk($sformatf("stream%0d_out_data", k), out_data_o, k - 1);
      end

      // Random traffic against an occupancy/order model
      for (int c = 0; c < 10000; c++) begin
         if (c < 9996) begin
            r_iv = ($urandom_range(0, 3) != 0);
            r_or = ($urandom_range(0, 2) != 0);
            r_fl = ($urandom_range(0, 63) == 0);
         end else begin
            r_iv = 1'b0;
            r_or = 1'b1;
            r_fl = 1'b0;
         end
         drive(r_fl, r_iv, $urandom, r_or);
         m_rdy = (sb.size() < 2) && !r_fl;
         m_vld = (sb.size() > 0);
         chk("rand_in_ready", {31'd0, in_ready_o}, {31'd0, m_rdy});
         chk("rand_out_valid", {31'd0, out_valid_o}, {31'd0, m_vld});
         if (m_vld) chk("rand_out_data", out_data_o, sb[0]);
         chk("rand_err", {31'd0, err_o}, 32'd0);
         if (m_vld && r_or) void'(sb.pop_front());
         if (r_fl) sb.delete();
         if (r_iv && m_rdy) sb.push_back(in_data_i);
      end
      $display("random phase done, %0d beats left in model", sb.size());
      chk("rand_drained", sb.size(), 32'd0);

      // Asynchronous reset while the slice holds two beats
      drive(1'b0, 1'b1, 32'h55, 1'b0);
      chk("ar_accept_rdy", {31'd0, in_ready_o}, 32'd1);
      drive(1'b0, 1'b1, 32'h66, 1'b0);
      chk("ar_one_data", out_data_o, 32'h55);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("ar_full_rdy", {31'd0, in_ready_o}, 32'd0);
      #2 rst_ni = 1'b0;
      #1;
      $display("async reset: rdy=%0b vld=%0b dout=%h", in_ready_o, out_valid_o, out_data_o);
      chk("ar_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk("ar_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("ar_out_data", out_data_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("ar_rel_rdy", {31'd0, in_ready_o}, 32'd0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("ar_rel_rdy_after_edge", {31'd0, in_ready_o}, 32'd1);
      chk("ar_rel_vld_after_edge", {31'd0, out_valid_o}, 32'd0);

`ifdef PRIM_SKID_SLICE_PARITY_EN
      drive(1'b0, 1'b1, 32'h1, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("par_clean", {31'd0, err_o}, 32'd0);
      force dut.main_reg = 33'h0_0000_0001;
      #1;
      chk("par_flip_err", {31'd0, err_o}, 32'd1);
      release dut.main_reg;
      drive(1'b0, 1'b1, 32'h3, 1'b1);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("par_reload_data", out_data_o, 32'h3);
      chk("par_reload_err", {31'd0, err_o}, 32'd0);
`else
      drive(1'b0, 1'b1, 32'h1, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("noparity_err", {31'd0, err_o}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
